tm_qm_depth_ctr: RTL and testbench

TM_QM_DEPTH_CTR -- requirements
Module: tm_qm_depth_ctr

---
 rtl/tm_qm_pkg.sv | 13 +
 rtl/ram_1r1w.sv | 27 ++
 rtl/tm_qm_depth_ctr.sv | 198 +++++++++++++++++++
 tb/tb_tm_qm_depth_ctr.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tm_qm_pkg.sv
// rtl/tm_qm_pkg.sv - shared constants and init-state encoding for the queue-manager depth counter
package tm_qm_pkg;

  localparam int TM_QM_QID_BITS   = 6;
  localparam int TM_QM_DEPTH_BITS = 12;

  typedef enum logic [1:0] {
    INIT_IDLE  = 2'd0,
    INIT_CLEAR = 2'd1,
    INIT_DONE  = 2'd2
  } init_state_e;

endpackage

// File: rtl/ram_1r1w.sv
// rtl/ram_1r1w.sv - one-read one-write synchronous RAM, registered read, old data on same-address collision
module ram_1r1w #(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data
);

  logic [DATA_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];

  // Storage array write and registered read; a same-cycle read sees the pre-write contents
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/tm_qm_depth_ctr.sv
// rtl/tm_qm_depth_ctr.sv - per-queue depth counter with 3-stage read-modify-write pipeline and clear sweep
// Optional threshold compare (thresh / over_thresh) is built when TM_QM_DEPTH_THRESH_EN is defined.
module tm_qm_depth_ctr
  import tm_qm_pkg::*;
#(
  parameter int QID_BITS   = TM_QM_QID_BITS,
  parameter int DEPTH_BITS = TM_QM_DEPTH_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enq_req,
  input  logic [QID_BITS-1:0]   enq_qid,
  output logic                  enq_ready,
  input  logic                  deq_req,
  input  logic [QID_BITS-1:0]   deq_qid,
  output logic                  enq_ack,
  output logic                  enq_to_empty,
  output logic                  deq_ack,
  output logic                  deq_from_emptyp2,
  output logic                  deq_to_empty,
  output logic                  ovf_err,
  output logic                  unf_err,
  output logic                  init_done
`ifdef TM_QM_DEPTH_THRESH_EN
  ,
  input  logic [DEPTH_BITS-1:0] thresh,
  output logic                  over_thresh
`endif
);

  localparam logic [DEPTH_BITS-1:0] DEPTH_MAX  = '1;
  localparam logic [DEPTH_BITS-1:0] DEPTH_ZERO = '0;
  localparam logic [DEPTH_BITS-1:0] DEPTH_TWO  = DEPTH_BITS'(2);

  init_state_e           state_q, state_d;
  logic [QID_BITS-1:0]   clr_cnt_q, clr_cnt_d;
  logic                  clr_we;

  logic                  done;
  logic                  enq_acc, deq_acc;
  logic                  s0_valid;
  logic [QID_BITS-1:0]   s0_qid;

  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_enq_q, s1_enq_d;
  logic                  s1_deq_q, s1_deq_d;
  logic [QID_BITS-1:0]   s1_qid_q, s1_qid_d;
  logic [DEPTH_BITS-1:0] s1_old, s1_new;

  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_enq_q, s2_enq_d;
  logic                  s2_deq_q, s2_deq_d;
  logic [QID_BITS-1:0]   s2_qid_q, s2_qid_d;
  logic [DEPTH_BITS-1:0] s2_old_q, s2_old_d;
  logic [DEPTH_BITS-1:0] s2_new_q, s2_new_d;

  logic                  s3_valid_q, s3_valid_d;
  logic [QID_BITS-1:0]   s3_qid_q, s3_qid_d;
  logic [DEPTH_BITS-1:0] s3_new_q, s3_new_d;

  logic [DEPTH_BITS-1:0] ram_rd_data;
  logic                  ram_we;
  logic [QID_BITS-1:0]   ram_waddr;
  logic [DEPTH_BITS-1:0] ram_wdata;

  // Init FSM next state: one idle cycle, then sweep every qid to zero, then stay done
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      INIT_IDLE: begin
        state_d   = INIT_CLEAR;
        clr_cnt_d = '0;
      end
      INIT_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + QID_BITS'(1);
        if (clr_cnt_q == '1) begin
          state_d = INIT_DONE;
        end
      end
      INIT_DONE: begin
        state_d = INIT_DONE;
      end
      default: begin
        state_d = INIT_IDLE;
      end
    endcase
  end

  // Init FSM state and sweep counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INIT_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Dequeue always wins the single read port; a same-qid enqueue rides along as a combined op
  always_comb begin
    done      = (state_q == INIT_DONE);
    deq_acc   = ~reset & done & deq_req;
    enq_ready = ~reset & done & ~(deq_req & (deq_qid != enq_qid));
    enq_acc   = enq_req & enq_ready;
    s0_valid  = enq_acc | deq_acc;
    s0_qid    = deq_acc ? deq_qid : enq_qid;
  end

  // Stage 1: pick the freshest depth (stage-2 write, then last committed write, then RAM) and step it
  always_comb begin
    if (s2_valid_q && (s2_qid_q == s1_qid_q)) begin
      s1_old = s2_new_q;
    end else if (s3_valid_q && (s3_qid_q == s1_qid_q)) begin
      s1_old = s3_new_q;
    end else begin
      s1_old = ram_rd_data;
    end
    case ({s1_enq_q, s1_deq_q})
      2'b10:   s1_new = (s1_old == DEPTH_MAX)  ? s1_old : s1_old + DEPTH_BITS'(1);
      2'b01:   s1_new = (s1_old == DEPTH_ZERO) ? s1_old : s1_old - DEPTH_BITS'(1);
      default: s1_new = s1_old;
    endcase
  end

  // Pipeline register inputs; reset drops every in-flight operation
  always_comb begin
    s1_valid_d = ~reset & s0_valid;
    s1_enq_d   = enq_acc;
    s1_deq_d   = deq_acc;
    s1_qid_d   = s0_qid;
    s2_valid_d = ~reset & s1_valid_q;
    s2_enq_d   = s1_enq_q;
    s2_deq_d   = s1_deq_q;
    s2_qid_d   = s1_qid_q;
    s2_old_d   = s1_old;
    s2_new_d   = s1_new;
    s3_valid_d = ~reset & s2_valid_q;
    s3_qid_d   = s2_qid_q;
    s3_new_d   = s2_new_q;
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    s1_valid_q <= s1_valid_d;
    s1_enq_q   <= s1_enq_d;
    s1_deq_q   <= s1_deq_d;
    s1_qid_q   <= s1_qid_d;
    s2_valid_q <= s2_valid_d;
    s2_enq_q   <= s2_enq_d;
    s2_deq_q   <= s2_deq_d;
    s2_qid_q   <= s2_qid_d;
    s2_old_q   <= s2_old_d;
    s2_new_q   <= s2_new_d;
    s3_valid_q <= s3_valid_d;
    s3_qid_q   <= s3_qid_d;
    s3_new_q   <= s3_new_d;
  end

  // Write port: clear sweep and stage-2 writeback never overlap
  always_comb begin
    ram_we    = clr_we | s2_valid_q;
    ram_waddr = clr_we ? clr_cnt_q : s2_qid_q;
    ram_wdata = clr_we ? DEPTH_ZERO : s2_new_q;
  end

  ram_1r1w #(
    .ADDR_BITS (QID_BITS),
    .DATA_BITS (DEPTH_BITS)
  ) u_depth_ram (
    .clk     (clk),
    .rd_en   (s0_valid),
    .rd_addr (s0_qid),
    .rd_data (ram_rd_data),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata)
  );

  // Acks and status decode from the stage-2 op; a combined enq+deq never flags over/underflow
  always_comb begin
    init_done        = done;
    enq_ack          = s2_valid_q & s2_enq_q;
    deq_ack          = s2_valid_q & s2_deq_q;
    enq_to_empty     = enq_ack & (s2_old_q == DEPTH_ZERO);
    ovf_err          = enq_ack & ~s2_deq_q & (s2_old_q == DEPTH_MAX);
    deq_from_emptyp2 = deq_ack & (s2_old_q >= DEPTH_TWO);
    deq_to_empty     = deq_ack & (s2_new_q == DEPTH_ZERO);
    unf_err          = deq_ack & ~s2_enq_q & (s2_old_q == DEPTH_ZERO);
`ifdef TM_QM_DEPTH_THRESH_EN
    over_thresh      = s2_valid_q & (s2_new_q > thresh);
`endif
  end

endmodule

// File: tb/tb_tm_qm_depth_ctr.sv
// tb/tb_tm_qm_depth_ctr.sv - scoreboard bench for tm_qm_depth_ctr against a saturating depth-array model
module tb_tm_qm_depth_ctr;

  localparam int QB   = 6;
  localparam int DB   = 2;
  localparam int NQ   = 1 << QB;
  localparam int DMAX = (1 << DB) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enq_req = 1'b0;
  logic [QB-1:0] enq_qid = '0;
  logic          enq_ready;
  logic          deq_req = 1'b0;
  logic [QB-1:0] deq_qid = '0;
  logic          enq_ack, enq_to_empty, deq_ack, deq_from_emptyp2, deq_to_empty;
  logic          ovf_err, unf_err, init_done;
  logic          ot;

`ifdef TM_QM_DEPTH_THRESH_EN
  logic [DB-1:0] thresh = DB'(2);
  logic          over_thresh;
  assign ot = over_thresh;
`else
  assign ot = 1'b0;
`endif

  tm_qm_depth_ctr #(
    .QID_BITS   (QB),
    .DEPTH_BITS (DB)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enq_req          (enq_req),
    .enq_qid          (enq_qid),
    .enq_ready        (enq_ready),
    .deq_req          (deq_req),
    .deq_qid          (deq_qid),
    .enq_ack          (enq_ack),
    .enq_to_empty     (enq_to_empty),
    .deq_ack          (deq_ack),
    .deq_from_emptyp2 (deq_from_emptyp2),
    .deq_to_empty     (deq_to_empty),
    .ovf_err          (ovf_err),
    .unf_err          (unf_err),
    .init_done        (init_done)
`ifdef TM_QM_DEPTH_THRESH_EN
    ,
    .thresh           (thresh),
    .over_thresh      (over_thresh)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] flags;
  } exp_t;

  exp_t sb[$];
  int   depth[NQ];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit thr_hit(input int nd);
`ifdef TM_QM_DEPTH_THRESH_EN
    return nd > int'(thresh);
`else
    return (nd < 0);
`endif
  endfunction

  // flags = {enq_ack, enq_to_empty, ovf_err, deq_ack, deq_from_emptyp2, deq_to_empty, unf_err, over_thresh}
  task automatic apply_model(input bit ea, input int eq, input bit da, input int dq);
    logic [7:0] f;
    int old, nd;
    f = '0;
    if (!ea && !da) return;
    if (ea && da && eq == dq) begin
      old = depth[eq];
      f = {1'b1, old == 0, 1'b0, 1'b1, old >= 2, old == 0, 1'b0, thr_hit(old)};
    end else begin
      if (ea) begin
        old = depth[eq];
        nd  = (old == DMAX) ? old : old + 1;
        depth[eq] = nd;
        f[7] = 1'b1; f[6] = (old == 0); f[5] = (old == DMAX);
        f[0] = f[0] | thr_hit(nd);
      end
      if (da) begin
        old = depth[dq];
        nd  = (old == 0) ? 0 : old - 1;
        depth[dq] = nd;
        f[4] = 1'b1; f[3] = (old >= 2); f[2] = (nd == 0); f[1] = (old == 0);
        f[0] = f[0] | thr_hit(nd);
      end
    end
    sb.push_back('{due: cyc + 2, flags: f});
  endtask

  task automatic step(input bit er, input int eq, input bit dr, input int dq, output bit acc);
    bit exp_rdy;
    @(negedge clk);
    enq_req = er;
    enq_qid = QB'(eq);
    deq_req = dr;
    deq_qid = QB'(dq);
    #1;
    exp_rdy = !(dr && (eq != dq));
    check("enq_ready", {31'd0, enq_ready}, {31'd0, exp_rdy});
    acc = er && enq_ready;
    apply_model(acc, eq, dr, dq);
  endtask

  task automatic reset_and_init();
    int n;
    @(negedge clk);
    reset = 1'b1;
    enq_req = 1'b0;
    deq_req = 1'b0;
    sb.delete();
    for (int q = 0; q < NQ; q++) depth[q] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (n < NQ + 20) begin
      @(posedge clk);
      #1;
      n++;
      if (init_done) break;
    end
    check("init_cycles", n, NQ + 1);
  endtask

  // Output monitor: every ack must line up with the oldest expected result, at its due cycle
  always @(negedge clk) begin
    logic [7:0] got;
    exp_t e;
    got = {enq_ack, enq_to_empty, ovf_err, deq_ack, deq_from_emptyp2, deq_to_empty, unf_err, ot};
    if (!reset) begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("ack_flags", {24'd0, got}, {24'd0, e.flags});
      end else if (enq_ack || deq_ack) begin
        check("spurious_ack", {24'd0, got}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit pend;
    int peq, dq;
    bit dr;

    repeat (3) @(posedge clk);
    #1;
    check("rst_init_done", {31'd0, init_done}, 0);
    check("rst_enq_ready", {31'd0, enq_ready}, 0);
    check("rst_acks", {30'd0, enq_ack, deq_ack}, 0);
    check("rst_errs", {30'd0, ovf_err, unf_err}, 0);

    reset_and_init();

    // dequeue from an empty queue after the sweep
    step(1'b0, 0, 1'b1, 5, acc);

    // three back-to-back enqueues then three dequeues on one queue
    repeat (3) step(1'b1, 7, 1'b0, 0, acc);
    repeat (3) step(1'b0, 0, 1'b1, 7, acc);

    // same-cycle enqueue and dequeue to one empty queue
    step(1'b1, 9, 1'b1, 9, acc);
    check("same_qid_enq_acc", {31'd0, acc}, 1);
    step(1'b0, 0, 1'b1, 9, acc);

    // enqueue blocked by a dequeue to another queue, accepted next cycle
    step(1'b1, 1, 1'b1, 2, acc);
    check("enq_blocked", {31'd0, acc}, 0);
    step(1'b1, 1, 1'b0, 0, acc);
    check("enq_retry_acc", {31'd0, acc}, 1);

    // saturation at all-ones, then drain to read the depth back
    repeat (4) step(1'b1, 0, 1'b0, 0, acc);
    repeat (4) step(1'b0, 0, 1'b1, 0, acc);

`ifdef TM_QM_DEPTH_THRESH_EN
    repeat (3) step(1'b1, 30, 1'b0, 0, acc);
`endif

    // randomized traffic on a few queues to stress forwarding and arbitration
    pend = 1'b0;
    peq  = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 99) < 60);
        peq  = $urandom_range(0, 7);
      end
      dr = ($urandom_range(0, 99) < 45);
      dq = $urandom_range(0, 7);
      step(pend, peq, dr, dq, acc);
      if (acc) pend = 1'b0;
    end
    repeat (4) step(1'b0, 0, 1'b0, 0, acc);
    check("sb_drained", sb.size(), 0);

    // reset while an op is in flight: no ack, sweep restarts, depth cleared
    step(1'b1, 20, 1'b0, 0, acc);
    @(negedge clk);
    reset = 1'b1;
    enq_req = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    check("reset_discard", {30'd0, enq_ack, deq_ack}, 0);
    check("reset_init_done", {31'd0, init_done}, 0);
    reset_and_init();
    step(1'b0, 0, 1'b1, 20, acc);
    repeat (4) step(1'b0, 0, 1'b0, 0, acc);
    check("sb_final", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
